uart_rx_byte: RTL

Oversampling 8N1 UART receiver that converts the asynchronous `uart_txd_in` serial line of the Arty A7-100 top level into bytes. It feeds the downstream logic (LED / loopback / TX path) through a one-entry valid/ready output buffer. It synchronises the pin, rejects start-bit glitches, samples each bit at mid-bit and flags framing and overrun errors.

---
 rtl/uart_rx_byte.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: oversampling UART receiver with a one-entry valid/ready output buffer.
// The default frame is 8N1. Defining UART_RX_PARITY_EN switches it to 8E1 and enables
// parity_err. In the default build parity_err is tied low.
// The input is synchronised through two flops. Start-bit glitches are rejected, each bit
// is sampled mid-bit, and frame_err / overrun / parity_err are single-cycle pulses.
module uart_rx_byte #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    // The bit period is floored at 4 clocks so the half-bit point stays meaningful.
    localparam int CPB_RAW      = CLK_FREQ / BAUD;
    localparam int CLKS_PER_BIT = (CPB_RAW < 4) ? 4 : CPB_RAW;
    localparam int TW           = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
    } state_t;
`endif

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            rxs_q, rxs_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            deliver;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            parity_err_q, parity_err_d;
`endif

    // Next-state logic: synchroniser, frame FSM and the output buffer.
    always_comb begin
        state_d     = state_q;
        sync1_d     = rxd;
        rxs_d       = sync1_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    if (rxs_q) begin
                        // Line went back high before mid-start-bit: a glitch.
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d            = '0;
                    shift_d[bit_idx_q] = rxs_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (timer_q == BIT_LAST) begin
                    timer_d   = '0;
                    // Even parity: data bits plus parity bit must XOR to zero.
                    par_bad_d = (^shift_q) ^ rxs_q;
                    state_d   = S_STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_bad_q;
`endif
                    if (rxs_q) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                // Hold off until the line idles so a break gives a single frame_err.
                timer_d = '0;
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        // A new byte may replace the buffered one only if it is empty or being taken now.
        if (deliver) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_d;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset; synchroniser idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            timer_q     <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rxs_q       <= rxs_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
